// File: rtl/datapath_sequencer.sv
// datapath_sequencer: register file, data memory and add/sub ALU
// sequenced by a five-state controller, one micro-op per handshake.
module datapath_sequencer #(
  parameter int WIDTH     = 64,
  parameter int NREG      = 32,
  parameter int MEM_DEPTH = 64,
  parameter int IMM_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op_code,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  input  logic [IMM_W-1:0]         imm,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     ovf,
  output logic                     mem_fault,
  input  logic [$clog2(NREG)-1:0]  dbg_raddr,
  output logic [WIDTH-1:0]         dbg_rdata
);

  localparam int RW = $clog2(NREG);
  localparam int AW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [RW:0] LP_NREG =
    (RW+1)'(NREG);
  localparam logic [WIDTH:0] LP_DEPTH =
    (WIDTH+1)'(MEM_DEPTH);

  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]       r_op;
  logic [RW-1:0]    r_rd;
  logic [RW-1:0]    r_rs1;
  logic [RW-1:0]    r_rs2;
  logic [IMM_W-1:0] r_imm;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu;
  logic             r_alu_ovf;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_mem_q;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_mem  [MEM_DEPTH];

  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_fault;

  logic             w_accept;
  logic             w_is_ld;
  logic             w_is_st;
  logic             w_is_add;
  logic             w_is_sub;
  logic             w_is_mem;
  logic             w_legal;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_addr_bad;
  logic [WIDTH-1:0] w_wb_data;
  logic             w_rd_ok;
  logic             w_rs1_ok;
  logic             w_rs2_ok;
  logic             w_dbg_ok;
  logic             w_fin;
  logic             w_fin_fault;
  logic             w_rf_we;
  logic             w_mem_we;

  assign w_accept = (r_state == S_IDLE) && op_valid;

  assign w_is_ld  = (r_op == OP_LD);
  assign w_is_st  = (r_op == OP_ST);
  assign w_is_add = (r_op == OP_ADD);
  assign w_is_sub = (r_op == OP_SUB);
  assign w_is_mem = w_is_ld || w_is_st;
  assign w_legal  = (r_op <= OP_ADDI);

  // Works for WIDTH narrower than IMM_W too.
  assign w_imm_ext =
    WIDTH'({{WIDTH{r_imm[IMM_W-1]}}, r_imm});

  // Subtract is a + ~b + 1 through the same adder.
  assign w_opnd =
    w_is_sub ? ~r_b :
    w_is_add ?  r_b : w_imm_ext;

  assign w_sum =
    r_a + w_opnd + {{(WIDTH-1){1'b0}}, w_is_sub};

  assign w_ovf =
    (r_a[WIDTH-1] == w_opnd[WIDTH-1]) &&
    (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  assign w_addr_bad = ({1'b0, w_sum} >= LP_DEPTH);

  assign w_wb_data = w_is_ld ? r_mem_q : r_alu;

  assign w_rd_ok =
    (r_rd != '0) && ({1'b0, r_rd} < LP_NREG);
  assign w_rs1_ok =
    (r_rs1 != '0) && ({1'b0, r_rs1} < LP_NREG);
  assign w_rs2_ok =
    (r_rs2 != '0) && ({1'b0, r_rs2} < LP_NREG);
  assign w_dbg_ok =
    (dbg_raddr != '0) &&
    ({1'b0, dbg_raddr} < LP_NREG);

  assign dbg_rdata =
    w_dbg_ok ? r_regs[dbg_raddr] : '0;

  assign op_ready  = (r_state == S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign mem_fault = r_fault;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_next      = r_state;
    w_fin       = 1'b0;
    w_fin_fault = 1'b0;
    w_rf_we     = 1'b0;
    w_mem_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (op_valid) w_next = S_READ;
      end
      S_READ: begin
        if (!w_legal) begin
          w_next      = S_IDLE;
          w_fin       = 1'b1;
          w_fin_fault = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!w_is_mem) begin
          w_next = S_WB;
        end else if (w_addr_bad) begin
          w_next      = S_IDLE;
          w_fin       = 1'b1;
          w_fin_fault = 1'b1;
        end else begin
          w_next = S_MEM;
        end
      end
      S_MEM: begin
        if (w_is_st) begin
          w_next   = S_IDLE;
          w_fin    = 1'b1;
          w_mem_we = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_next  = S_IDLE;
        w_fin   = 1'b1;
        w_rf_we = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Op capture, operand fetch and ALU/address latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_alu_ovf <= 1'b0;
      r_addr    <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_code;
        r_rd  <= rd;
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        r_imm <= imm;
      end
      if (r_state == S_READ) begin
        r_a <= w_rs1_ok ? r_regs[r_rs1] : '0;
        r_b <= w_rs2_ok ? r_regs[r_rs2] : '0;
      end
      if (r_state == S_EXEC) begin
        r_alu     <= w_sum;
        r_alu_ovf <= w_ovf && !w_is_mem;
        r_addr    <= w_sum[AW-1:0];
      end
    end
  end

  // Register file; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_rf_we && w_rd_ok) begin
      r_regs[r_rd] <= w_wb_data;
    end
  end

  // Data memory: no reset, synchronous read.
  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[r_addr] <= r_b;
    if (r_state == S_MEM)
      r_mem_q <= r_mem[r_addr];
  end

  // Completion outputs, loaded on the edge into IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_fault <= w_fin_fault;
        r_ovf   <= (r_state == S_WB) && r_alu_ovf;
        if (!w_fin_fault)
          r_result <= (r_state == S_MEM) ?
                      r_b : w_wb_data;
      end
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: 64-bit and 8-bit instances driven in
// lockstep, checked every cycle against a per-op outcome model.
module tb_datapath_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [4:0]  rd, rs1, rs2, dbg_raddr;
  logic [11:0] imm;

  logic        rdy64, done64, ovf64, flt64;
  logic [63:0] res64, dbg64;
  logic        rdy8, done8, ovf8, flt8;
  logic [7:0]  res8, dbg8;

  datapath_sequencer #(
    .WIDTH(64), .NREG(32), .MEM_DEPTH(64), .IMM_W(12)
  ) dut64 (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(rdy64),
    .op_code(op_code), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .done(done64), .result(res64),
    .ovf(ovf64), .mem_fault(flt64),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg64)
  );

  datapath_sequencer #(
    .WIDTH(8), .NREG(32), .MEM_DEPTH(64), .IMM_W(12)
  ) dut8 (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(rdy8),
    .op_code(op_code), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .done(done8), .result(res8),
    .ovf(ovf8), .mem_fault(flt8),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg8)
  );

  logic        d_done [2];
  logic        d_rdy  [2];
  logic        d_ovf  [2];
  logic        d_flt  [2];
  logic [63:0] d_res  [2];
  logic [63:0] d_dbg  [2];

  assign d_done[0] = done64;
  assign d_done[1] = done8;
  assign d_rdy[0]  = rdy64;
  assign d_rdy[1]  = rdy8;
  assign d_ovf[0]  = ovf64;
  assign d_ovf[1]  = ovf8;
  assign d_flt[0]  = flt64;
  assign d_flt[1]  = flt8;
  assign d_res[0]  = res64;
  assign d_res[1]  = {56'h0, res8};
  assign d_dbg[0]  = dbg64;
  assign d_dbg[1]  = {56'h0, dbg8};

  int ntests = 0;
  int nfail  = 0;
  int pcyc   = 0;

  logic [63:0] m_reg [2][32];
  logic [63:0] m_mem [2][64];
  logic [63:0] last_res [2];
  logic        exp_ovf [2];
  logic        exp_flt [2];
  int          exp_cyc [2];
  bit          pend    [2];

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b",
               nm, act, exp);
    end
  endtask

  function automatic logic signed [65:0] sv(
    input logic [63:0] x, input int w);
    if (w == 64) return $signed({{2{x[63]}}, x});
    return $signed({{58{x[7]}}, x[7:0]});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) m_reg[i][r] = '0;
      last_res[i] = '0;
      pend[i] = 1'b0;
    end
  endtask

  // Outcome of one op on instance i, from the op rules alone.
  task automatic model_step(input int i,
                            input logic [2:0] op,
                            input int d, s1, s2,
                            input logic [11:0] iv,
                            output int lat);
    logic [63:0] mask, a, b, s, r, addr;
    logic signed [65:0] ex, lim;
    int w;
    w    = (i == 0) ? 64 : 8;
    mask = (i == 0) ? '1 : 64'hFF;
    a    = m_reg[i][s1];
    b    = m_reg[i][s2];
    s    = {{52{iv[11]}}, iv} & mask;
    lim  = 66'sd1 <<< (w - 1);
    ex   = '0;
    exp_ovf[i] = 1'b0;
    exp_flt[i] = 1'b0;
    case (op)
      3'd2, 3'd3, 3'd4: begin
        if (op == 3'd2)      ex = sv(a, w) + sv(b, w);
        else if (op == 3'd3) ex = sv(a, w) - sv(b, w);
        else                 ex = sv(a, w) + sv(s, w);
        r = ex[63:0] & mask;
        exp_ovf[i] = (ex >= lim) || (ex < -lim);
        if (d != 0) m_reg[i][d] = r;
        last_res[i] = r;
        lat = 4;
      end
      3'd0, 3'd1: begin
        addr = (a + s) & mask;
        if (addr >= 64) begin
          exp_flt[i] = 1'b1;
          lat = 3;
        end else if (op == 3'd1) begin
          m_mem[i][addr[5:0]] = b;
          last_res[i] = b;
          lat = 4;
        end else begin
          r = m_mem[i][addr[5:0]];
          if (d != 0) m_reg[i][d] = r;
          last_res[i] = r;
          lat = 5;
        end
      end
      default: begin
        exp_flt[i] = 1'b1;
        lat = 2;
      end
    endcase
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && pcyc == exp_cyc[i]) begin
          chk1($sformatf("done[%0d]", i), d_done[i], 1'b1);
          chk1($sformatf("ready_done[%0d]", i), d_rdy[i], 1'b1);
          chk($sformatf("result[%0d]", i), d_res[i], last_res[i]);
          chk1($sformatf("ovf[%0d]", i), d_ovf[i], exp_ovf[i]);
          chk1($sformatf("fault[%0d]", i), d_flt[i], exp_flt[i]);
          pend[i] = 1'b0;
        end else begin
          chk1($sformatf("done_quiet[%0d]", i), d_done[i], 1'b0);
          if (pend[i])
            chk1($sformatf("ready_busy[%0d]", i), d_rdy[i], 1'b0);
        end
      end
    end
  end

  // Issue one op at a negedge and wait for both completions.
  task automatic do_op(input logic [2:0] op,
                       input int d, s1, s2, iv);
    int t;
    int lat;
    t = 0;
    while (!(rdy64 && rdy8) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      ntests++;
      nfail++;
      $display("FAIL ready_timeout: ready %b/%b", rdy64, rdy8);
      return;
    end
    op_code  = op;
    rd       = 5'(d);
    rs1      = 5'(s1);
    rs2      = 5'(s2);
    imm      = 12'(iv);
    op_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, op, d, s1, s2, 12'(iv), lat);
      exp_cyc[i] = pcyc + lat;
      pend[i] = 1'b1;
    end
    @(negedge clk);
    op_valid = 1'b0;
    t = 0;
    while ((pend[0] || pend[1]) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (pend[0] || pend[1]) begin
      ntests++;
      nfail++;
      $display("FAIL done_timeout: pending %b/%b",
               pend[0], pend[1]);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end
  endtask

  task automatic dbg_one(input int r,
                         input logic [63:0] lit);
    dbg_raddr = 5'(r);
    #1;
    chk($sformatf("dbg_lit x%0d", r), d_dbg[0], lit);
  endtask

  task automatic dbg_sweep(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r);
      #1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("%s x%0d[%0d]", tag, r, i),
            d_dbg[i], m_reg[i][r]);
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, opv, d, s1, s2, iv;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_code   = '0;
    rd        = '0;
    rs1       = '0;
    rs2       = '0;
    imm       = '0;
    dbg_raddr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("rst_ready[%0d]", i), d_rdy[i], 1'b1);
      chk1($sformatf("rst_done[%0d]", i), d_done[i], 1'b0);
      chk($sformatf("rst_result[%0d]", i), d_res[i], 64'h0);
      chk1($sformatf("rst_ovf[%0d]", i), d_ovf[i], 1'b0);
      chk1($sformatf("rst_fault[%0d]", i), d_flt[i], 1'b0);
    end
    dbg_sweep("rst_dbg");

    do_op(3'd4, 1, 0, 0, 7);
    chk("addi7", d_res[0], 64'd7);
    do_op(3'd4, 2, 0, 0, 3);
    chk("addi3", d_res[0], 64'd3);
    do_op(3'd2, 3, 1, 2, 0);
    chk("add10", d_res[0], 64'd10);
    chk1("add10_ovf", d_ovf[0], 1'b0);
    do_op(3'd3, 4, 3, 1, 0);
    chk("sub3", d_res[0], 64'd3);
    do_op(3'd4, 5, 0, 0, -1);
    chk("addi_m1", d_res[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_m1_w8", d_res[1], 64'hFF);
    dbg_one(1, 64'd7);
    dbg_one(2, 64'd3);
    dbg_one(3, 64'd10);
    dbg_one(4, 64'd3);
    @(negedge clk);

    do_op(3'd1, 0, 0, 3, 5);
    chk("st10", d_res[0], 64'd10);
    do_op(3'd0, 6, 1, 0, -2);
    chk("ld10", d_res[0], 64'd10);
    dbg_one(6, 64'd10);
    @(negedge clk);
    do_op(3'd0, 6, 0, 0, 64);
    chk1("ld_fault", d_flt[0], 1'b1);
    dbg_one(6, 64'd10);
    @(negedge clk);
    do_op(3'd7, 1, 2, 3, 0);
    chk1("illegal_fault", d_flt[0], 1'b1);
    do_op(3'd4, 0, 0, 0, 9);
    chk("addi_x0", d_res[0], 64'd9);
    dbg_one(0, 64'd0);
    @(negedge clk);

    do_op(3'd4, 1, 0, 0, 127);
    do_op(3'd4, 2, 0, 0, 1);
    do_op(3'd2, 3, 1, 2, 0);
    chk("w8_add_res", d_res[1], 64'h80);
    chk1("w8_add_ovf", d_ovf[1], 1'b1);
    do_op(3'd3, 4, 3, 2, 0);
    chk("w8_sub_res", d_res[1], 64'h7F);
    chk1("w8_sub_ovf", d_ovf[1], 1'b1);

    for (int r = 1; r < 32; r++)
      do_op(3'd4, r, 0, 0, $urandom_range(0, 4095));
    for (int a = 0; a < 64; a++)
      do_op(3'd1, 0, 0, $urandom_range(0, 31), a);

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 15);
      d  = $urandom_range(0, 31);
      s1 = $urandom_range(0, 31);
      s2 = $urandom_range(0, 31);
      iv = $urandom_range(0, 4095);
      if (k < 3)       opv = 0;
      else if (k < 6)  opv = 1;
      else if (k < 9)  opv = 2;
      else if (k < 12) opv = 3;
      else if (k < 15) opv = 4;
      else             opv = $urandom_range(5, 7);
      if (opv < 2 && $urandom_range(0, 1) == 1) begin
        s1 = 0;
        iv = $urandom_range(0, 80) - 8;
      end
      do_op(3'(opv), d, s1, s2, iv);
    end
    dbg_sweep("rand_dbg");

    op_code  = 3'd2;
    rd       = 5'd7;
    rs1      = 5'd1;
    rs2      = 5'd2;
    imm      = '0;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("abort_ready[%0d]", i), d_rdy[i], 1'b1);
      chk1($sformatf("abort_done[%0d]", i), d_done[i], 1'b0);
    end
    dbg_sweep("abort_dbg");
    do_op(3'd4, 7, 0, 0, 5);
    chk("after_abort", d_res[0], 64'd5);
    dbg_one(7, 64'd5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
